// File: rtl/seg7_pkg.sv
//------------------------------------------------------------------------------
// Module : seg7_pkg
// Brief  : Seven-segment types, hex glyph table and nibble-to-segment helper.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

    // Segment vector {g,f,e,d,c,b,a}, active-high polarity
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b0000000;

    localparam seg7_t SEG_HEX [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Unknown nibbles (X/Z) fall through to the default arm and decode as blank
    function automatic seg7_t hex2seg(input logic [3:0] nibble);
        seg7_t seg;
        case (nibble)
            4'h0:    seg = SEG_HEX[0];
            4'h1:    seg = SEG_HEX[1];
            4'h2:    seg = SEG_HEX[2];
            4'h3:    seg = SEG_HEX[3];
            4'h4:    seg = SEG_HEX[4];
            4'h5:    seg = SEG_HEX[5];
            4'h6:    seg = SEG_HEX[6];
            4'h7:    seg = SEG_HEX[7];
            4'h8:    seg = SEG_HEX[8];
            4'h9:    seg = SEG_HEX[9];
            4'hA:    seg = SEG_HEX[10];
            4'hB:    seg = SEG_HEX[11];
            4'hC:    seg = SEG_HEX[12];
            4'hD:    seg = SEG_HEX[13];
            4'hE:    seg = SEG_HEX[14];
            4'hF:    seg = SEG_HEX[15];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7_lut.sv
//------------------------------------------------------------------------------
// Module : hex_to_seg7_lut
// Brief  : Combinational nibble to active-high seven-segment glyph lookup.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_to_seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = hex2seg(nibble_i);
    end

endmodule

`default_nettype wire

// File: rtl/hex_seven_seg_decoder.sv
//------------------------------------------------------------------------------
// Module : hex_seven_seg_decoder
// Brief  : Registered hex-digit seven-segment decoder with blanking enable.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex_seven_seg_decoder
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] binary_in,
    output logic [6:0] decoder_out
);

    // Blank as seen on the pins, i.e. after polarity conversion
    localparam seg7_t BLANK_OUT = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    seg7_t w_lut_seg;
    seg7_t w_active_seg;
    seg7_t seg_d;
    seg7_t seg_q;

    hex_to_seg7_lut u_lut (
        .nibble_i (binary_in),
        .seg_o    (w_lut_seg)
    );

    assign w_active_seg = enable ? w_lut_seg : SEG_BLANK;

    generate
        if (ACTIVE_LOW) begin : g_active_low
            assign seg_d = ~w_active_seg;
        end else begin : g_active_high
            assign seg_d = w_active_seg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= BLANK_OUT;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign decoder_out = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_seven_seg_decoder.sv
//------------------------------------------------------------------------------
// Module : tb_hex_seven_seg_decoder
// Brief  : Self-checking bench for both output polarities of the decoder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hex_seven_seg_decoder;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] binary_in;
    logic [6:0] out_hi;
    logic [6:0] out_lo;

    int n_checks;
    int n_pass;

    // Lit segments of each hex glyph, by segment letter
    string SEGS [16] = '{
        "abcdef", "bc",     "abdeg",   "abcdg",
        "bcfg",   "acdfg",  "acdefg",  "abc",
        "abcdefg","abcfg",  "abcefg",  "cdefg",
        "adef",   "bcdeg",  "adefg",   "aefg"
    };

    hex_seven_seg_decoder #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .binary_in   (binary_in),
        .decoder_out (out_hi)
    );

    hex_seven_seg_decoder #(.ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .binary_in   (binary_in),
        .decoder_out (out_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] letters_to_vec(input string s);
        logic [6:0] v;
        v = 7'b0;
        for (int i = 0; i < s.len(); i++) begin
            v[s[i] - "a"] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [6:0] model(input logic en, input logic [3:0] n);
        return en ? letters_to_vec(SEGS[n]) : 7'b0;
    endfunction

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [6:0] exp_hi);
        check_eq({tag, "_hi"}, out_hi, exp_hi);
        check_eq({tag, "_lo"}, out_lo, ~exp_hi);
    endtask

    // Drive inputs, take one edge, then compare just after it
    task automatic step(input string tag, input logic en, input logic [3:0] n);
        enable    = en;
        binary_in = n;
        @(posedge clk);
        #1;
        check_both(tag, model(en, n));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        enable    = 1'b1;
        binary_in = 4'h8;

        #1;
        check_both("reset_init", 7'b0);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step($sformatf("sweep_%0h", i), 1'b1, 4'(i));
        end
        check_eq("sweep_F_lit", out_hi, 7'b1110001);

        step("blank", 1'b0, 4'h3);
        step("reenable", 1'b1, 4'h3);
        check_eq("reenable_lit", out_hi, 7'b1001111);

        step("lat_1", 1'b1, 4'h1);
        binary_in = 4'h2;
        @(negedge clk);
        check_eq("lat_hold", out_hi, 7'b0000110);
        @(posedge clk);
        #1;
        check_eq("lat_new", out_hi, 7'b1011011);

        step("lo_zero", 1'b1, 4'h0);
        check_eq("lo_zero_lit", out_lo, 7'b1000000);

        step("pre_rst", 1'b1, 4'h8);
        #2;
        rst = 1'b1;
        #1;
        check_both("rst_async", 7'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_both($sformatf("rst_hold_%0d", i), 7'b0);
        end
        rst = 1'b0;
        #2;
        check_both("rst_released", 7'b0);
        step("post_rst", 1'b1, 4'h8);
        step("lo_blank", 1'b0, 4'h5);
        check_eq("lo_blank_lit", out_lo, 7'b1111111);

        for (int i = 0; i < 60; i++) begin
            step($sformatf("rand_%0d", i), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
